lsu_mem_master: RTL

- Load/store initiator that drives the 64-bit virtual memory port (ren/addr/rData, wen/wMask/wData) on behalf of the execute stage.
- Accepts one load or store per valid/ready handshake and checks natural alignment.
- Forms the 8-byte-aligned bus address, byte mask and lane-shifted write data; extracts and sign- or zero-extends load data.
- Returns one response per request via valid/ready; sits between EXU/WBU and the memory model.

---
 rtl/lsu_pkg.sv | 42 ++++
 rtl/lsu_load_align.sv | 30 +++
 rtl/lsu_mem_master.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store memory master.
//   - SZ_B/SZ_H/SZ_W/SZ_D : request size encodings (1/2/4/8 bytes)
//   - lsu_state_e         : control FSM states
//   - size_mask()         : byte-lane mask of an access before lane shifting
//   - misaligned()        : natural-alignment check of an access
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_e;

  function automatic logic [7:0] size_mask(input logic [1:0] size);
    logic [7:0] m;
    case (size)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  // An access is aligned when its byte offset is a multiple of its size.
  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
    logic mis;
    case (size)
      SZ_H:    mis = (off[0] != 1'b0);
      SZ_W:    mis = (off[1:0] != 2'b00);
      SZ_D:    mis = (off != 3'b000);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: moves the addressed bytes of a 64-bit read beat down to
// bit 0 and sign- or zero-extends them to 64 bits.
//   raw       in  64  read data beat from memory
//   byte_off  in  3   byte offset of the access inside the beat
//   size      in  2   access size (SZ_B/H/W/D)
//   is_signed in  1   sign-extend (ignored for doubles)
//   data      out 64  extracted, extended load result
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [63:0] raw,
  input  logic [2:0]  byte_off,
  input  logic [1:0]  size,
  input  logic        is_signed,
  output logic [63:0] data
);

  logic [63:0] shifted;

  always_comb begin
    shifted = raw >> {byte_off, 3'b000};
    case (size)
      SZ_B:    data = {{56{is_signed & shifted[7]}},  shifted[7:0]};
      SZ_H:    data = {{48{is_signed & shifted[15]}}, shifted[15:0]};
      SZ_W:    data = {{32{is_signed & shifted[31]}}, shifted[31:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: single-outstanding load/store initiator on a 64-bit memory port.
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high. Once resp_valid is raised, resp_rdata/resp_err stay stable
// until the edge where resp_ready is seen high.
//
// Ports:
//   clock, reset            clock, asynchronous active-low reset
//   req_valid/req_ready     request handshake (ready only in IDLE)
//   req_wen, req_addr, req_size, req_signed, req_wdata   request fields
//   resp_valid/resp_ready   response handshake
//   resp_rdata, resp_err    extended load data (0 for stores/errors), misaligned flag
//   mem_ren, mem_addr, mem_rData              read strobe, aligned address, read data
//   mem_wen, mem_wMask, mem_wData             write strobe, lane mask, lane-shifted data
//   dbg_state               current FSM state (lsu_state_e encoding)
//
// Flow: IDLE -> ACCESS (strobe held WAIT_CYCLES+1 cycles) -> RESP -> IDLE.
// Misaligned requests go IDLE -> RESP directly with no memory traffic.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned ADDR_W      = 64
)
(
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [63:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [63:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [63:0]       mem_rData,
  output logic              mem_wen,
  output logic [7:0]        mem_wMask,
  output logic [63:0]       mem_wData,
  output logic [1:0]        dbg_state
);

  localparam logic [3:0] WAIT_CNT = 4'(WAIT_CYCLES);

  lsu_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic [63:0]       wdata_q, wdata_d;
  logic [63:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [63:0]       load_data;

  lsu_load_align u_load_align (
    .raw       (mem_rData),
    .byte_off  (addr_q[2:0]),
    .size      (size_q),
    .is_signed (signed_q),
    .data      (load_data)
  );

  // State and captured-request registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      wen_q    <= 1'b0;
      addr_q   <= '0;
      size_q   <= '0;
      signed_q <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wen_q    <= wen_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Next-state and datapath capture.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wen_d    = wen_q;
    addr_d   = addr_q;
    size_d   = size_q;
    signed_d = signed_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          wen_d    = req_wen;
          addr_d   = req_addr;
          size_d   = req_size;
          signed_d = req_signed;
          wdata_d  = req_wdata;
          rdata_d  = '0;
          if (misaligned(req_size, req_addr[2:0])) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            err_d   = 1'b0;
            cnt_d   = WAIT_CNT;
            state_d = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        // The strobe stays up while the counter runs down; the read beat
        // is taken in the last strobe cycle.
        if (cnt_q == 4'd0) begin
          if (!wen_q) rdata_d = load_data;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded purely from the current state and captured request.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    mem_ren    = 1'b0;
    mem_wen    = 1'b0;
    mem_addr   = '0;
    mem_wMask  = '0;
    mem_wData  = '0;
    dbg_state  = state_q;
    case (state_q)
      ST_IDLE: req_ready = 1'b1;
      ST_ACCESS: begin
        mem_addr = {addr_q[ADDR_W-1:3], 3'b000};
        if (wen_q) begin
          mem_wen   = 1'b1;
          mem_wMask = size_mask(size_q) << addr_q[2:0];
          mem_wData = wdata_q << {addr_q[2:0], 3'b000};
        end else begin
          mem_ren = 1'b1;
        end
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
        resp_err   = err_q;
      end
      default: ;
    endcase
  end

endmodule
